// File: rtl/jk_from_sr_reg.sv
// ---------------------------------------------------------------------------
// jk_from_sr_reg
//
// WIDTH-bit JK register whose bits are stored in SR cells. Each cell is fed
// by JK-to-SR excitation logic (s = en & j & ~q, r = en & k & q), so the JK
// toggle case (j=k=1) becomes a plain set or clear and the SR cell never
// sees s=r=1. Alongside the register, a saturating counter accumulates the
// number of individual bit toggles for activity monitoring. A sticky flag
// records any cell that saw s=r=1; it acts as a self-check and stays low in
// normal operation.
//
// Parameters
//   WIDTH      number of JK bits (1..32)
//   CNT_W      width of the saturating toggle counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears q, toggle_cnt, illegal)
//   en         update enable; when low all bits hold and j/k are ignored
//   j, k       per-bit J and K inputs
//   clr_cnt    synchronous clear of toggle_cnt and illegal (wins over count)
//   q          registered register state
//   toggle_cnt registered saturating count of bit toggles
//   illegal    registered sticky flag: some SR cell saw s=r=1
// ---------------------------------------------------------------------------
module jk_from_sr_reg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             illegal
);

    // Six extra bits hold the largest per-cycle increment (32 toggles) on
    // top of a saturated count without wrapping.
    localparam int SUM_W = CNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = {{6{1'b0}}, {CNT_W{1'b1}}};

    // Number of set bits in a toggle-event vector, widened to the sum width.
    function automatic logic [SUM_W-1:0] count_ones(input logic [WIDTH-1:0] v);
        logic [SUM_W-1:0] acc;
        acc = {SUM_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + {{(SUM_W-1){1'b0}}, v[i]};
        end
        return acc;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             illegal_r;

    logic [WIDTH-1:0] s_s;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] tog_s;
    logic [SUM_W-1:0] sum_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             illegal_next_s;

    // JK-to-SR excitation and the SR cell next-state for every bit.
    always_comb begin
        s_s      = {WIDTH{en}} & j & ~q_r;
        r_s      = {WIDTH{en}} & k & q_r;
        q_next_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            case ({s_s[i], r_s[i]})
                2'b10:   q_next_s[i] = 1'b1;
                2'b01:   q_next_s[i] = 1'b0;
                default: q_next_s[i] = q_r[i];   // 00 hold, 11 hold (flagged)
            endcase
        end
    end

    // Toggle accounting with saturation, sticky illegal flag, clear priority.
    always_comb begin
        tog_s          = {WIDTH{en}} & j & k;
        sum_s          = {{6{1'b0}}, cnt_r} + count_ones(tog_s);
        cnt_next_s     = cnt_r;
        illegal_next_s = illegal_r;
        if (clr_cnt) begin
            // Toggle events of this cycle are intentionally discarded.
            cnt_next_s     = {CNT_W{1'b0}};
            illegal_next_s = 1'b0;
        end else begin
            if (sum_s > CNT_MAX) begin
                cnt_next_s = {CNT_W{1'b1}};
            end else begin
                cnt_next_s = sum_s[CNT_W-1:0];
            end
            illegal_next_s = illegal_r | (|(s_s & r_s));
        end
    end

    // State registers: register bits, toggle counter, sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r       <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            q_r       <= q_next_s;
            cnt_r     <= cnt_next_s;
            illegal_r <= illegal_next_s;
        end
    end

    assign q          = q_r;
    assign toggle_cnt = cnt_r;
    assign illegal    = illegal_r;

endmodule
